// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the register-bank writeback path:
// FSM encoding, RV32I load funct3 codes and the latched load request.
package writeback_unit_pkg;

  localparam int unsigned REG_INDEX_WIDTH = 5;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned NUM_REGS        = 32'd1 << REG_INDEX_WIDTH;
  localparam int unsigned FUNCT3_WIDTH    = 3;
  localparam int unsigned OFFSET_WIDTH    = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    COMMIT    = 2'd2
  } wb_state_e;

  localparam logic [FUNCT3_WIDTH-1:0] LB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] LH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] LW  = 3'b010;
  localparam logic [FUNCT3_WIDTH-1:0] LBU = 3'b100;
  localparam logic [FUNCT3_WIDTH-1:0] LHU = 3'b101;

  typedef struct packed {
    logic [REG_INDEX_WIDTH-1:0] rd;
    logic [FUNCT3_WIDTH-1:0]    funct3;
    logic [OFFSET_WIDTH-1:0]    offset;
  } load_req_t;

  // One-hot register mask; x0 never appears since it is hardwired to zero.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_INDEX_WIDTH-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (rd != '0) mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/writeback_unit_load_extract.sv
// RV32I load lane selection and sign/zero extension, with a fault flag for
// misaligned or unsupported funct3 encodings. Purely combinational.
module load_extract
  import writeback_unit_pkg::*;
(
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [XLEN-1:0]         word,
  output logic [XLEN-1:0]         value,
  output logic                    fault
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(word >> {offset, 3'b000});
    half_lane = 16'(word >> {offset[1], 4'b0000});
    value     = '0;
    fault     = 1'b0;
    case (funct3)
      LB:  value = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LBU: value = {{(XLEN-8){1'b0}}, byte_lane};
      LH: begin
        value = {{(XLEN-16){half_lane[15]}}, half_lane};
        fault = offset[0];
      end
      LHU: begin
        value = {{(XLEN-16){1'b0}}, half_lane};
        fault = offset[0];
      end
      LW: begin
        value = word;
        fault = (offset != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Single write port driver for the register bank: merges ALU results with
// one outstanding variable-latency load and exports its pending destination.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [REG_INDEX_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]            alu_value,
  input  logic                       load_issue,
  input  logic [REG_INDEX_WIDTH-1:0] load_rd,
  input  logic [FUNCT3_WIDTH-1:0]    load_funct3,
  input  logic [OFFSET_WIDTH-1:0]    load_offset,
  input  logic                       mem_rvalid,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic                       write_enabled,
  output logic [REG_INDEX_WIDTH-1:0] write_index,
  output logic [XLEN-1:0]            write_value,
  output logic [NUM_REGS-1:0]        pending_mask,
  output logic                       load_busy,
  output logic                       load_error
);

  wb_state_e                  state;
  wb_state_e                  state_next;
  load_req_t                  req;
  logic [XLEN-1:0]            load_word;
  logic [TIMEOUT_WIDTH-1:0]   count;
  logic                       timeout_hit;

  logic [XLEN-1:0]            ext_value;
  logic                       ext_fault;

  logic                       write_enabled_next;
  logic [REG_INDEX_WIDTH-1:0] write_index_next;
  logic [XLEN-1:0]            write_value_next;
  logic                       load_error_next;

  load_extract u_extract (
    .funct3 (req.funct3),
    .offset (req.offset),
    .word   (load_word),
    .value  (ext_value),
    .fault  (ext_fault)
  );

  // Last wait cycle before the load is abandoned.
  assign timeout_hit = (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (load_issue) state_next = WAIT_LOAD;
      WAIT_LOAD: begin
        if (mem_rvalid)       state_next = COMMIT;
        else if (timeout_hit) state_next = IDLE;
      end
      COMMIT:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Port arbitration and next values for the registered write port.
  always_comb begin
    alu_ready          = 1'b1;
    write_enabled_next = 1'b0;
    write_index_next   = write_index;
    write_value_next   = write_value;
    load_error_next    = 1'b0;
    case (state)
      IDLE: alu_ready = 1'b1;
      WAIT_LOAD: begin
        alu_ready = (alu_rd != req.rd);
        if (mem_rvalid)       load_error_next = ext_fault;
        else if (timeout_hit) load_error_next = 1'b1;
      end
      COMMIT: begin
        alu_ready = 1'b0;
        if (!ext_fault && (req.rd != '0)) begin
          write_enabled_next = 1'b1;
          write_index_next   = req.rd;
          write_value_next   = ext_value;
        end
      end
      default: alu_ready = 1'b0;
    endcase
    if (alu_valid && alu_ready && (alu_rd != '0)) begin
      write_enabled_next = 1'b1;
      write_index_next   = alu_rd;
      write_value_next   = alu_value;
    end
  end

  assign load_busy    = (state != IDLE);
  assign pending_mask = load_busy ? rd_onehot(req.rd) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enabled <= 1'b0;
      write_index   <= '0;
      write_value   <= '0;
      load_error    <= 1'b0;
      count         <= '0;
      req           <= '0;
      load_word     <= '0;
    end else begin
      write_enabled <= write_enabled_next;
      write_index   <= write_index_next;
      write_value   <= write_value_next;
      load_error    <= load_error_next;
      if (state == IDLE && load_issue) begin
        req   <= '{rd: load_rd, funct3: load_funct3, offset: load_offset};
        count <= '0;
      end else if (state == WAIT_LOAD) begin
        count <= count + TIMEOUT_WIDTH'(1);
        if (mem_rvalid) load_word <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: stimulus pushes expected register writes
// and load errors into queues that a negedge monitor pops and compares.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_value = '0;
  logic        load_issue = 1'b0;
  logic [4:0]  load_rd = '0;
  logic [2:0]  load_funct3 = '0;
  logic [1:0]  load_offset = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        write_enabled;
  logic [4:0]  write_index;
  logic [31:0] write_value;
  logic [31:0] pending_mask;
  logic        load_busy;
  logic        load_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } wr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
    bit          err;
    int          dly;
  } ld_t;

  wr_t        exp_wr[$];
  logic [4:0] exp_err[$];
  ld_t        loads[11];

  writeback_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_value     (alu_value),
    .load_issue    (load_issue),
    .load_rd       (load_rd),
    .load_funct3   (load_funct3),
    .load_offset   (load_offset),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .write_enabled (write_enabled),
    .write_index   (write_index),
    .write_value   (write_value),
    .pending_mask  (pending_mask),
    .load_busy     (load_busy),
    .load_error    (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write strobe and error pulse must be expected.
  always @(negedge clk) begin
    if (!rst) begin
      if (write_enabled) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got x%0d=%h expected no write", write_index, write_value);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write_index", 32'(write_index), 32'(e.idx));
          chk("write_value", write_value, e.val);
        end
      end
      if (load_error) begin
        checks++;
        if (exp_err.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load_error: got 1 expected 0");
        end else begin
          void'(exp_err.pop_front());
        end
      end
    end
  end

  task automatic do_load(input ld_t l);
    logic [31:0] mask;
    mask = (l.rd != 5'd0) ? (32'd1 << l.rd) : 32'd0;
    step();
    load_issue  = 1'b1;
    load_rd     = l.rd;
    load_funct3 = l.f3;
    load_offset = l.off;
    step();
    load_issue = 1'b0;
    #1;
    chk("pending_during_wait", pending_mask, mask);
    chk("busy_during_wait", 32'(load_busy), 32'd1);
    repeat (l.dly) step();
    mem_rvalid = 1'b1;
    mem_rdata  = l.data;
    if (l.err) exp_err.push_back(l.rd);
    else if (l.rd != 5'd0) exp_wr.push_back('{idx: l.rd, val: l.exp});
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("error_in_commit", 32'(load_error), 32'(l.err));
    chk("no_write_in_commit", 32'(write_enabled), 32'd0);
    step();
    #1;
    chk("write_after_commit", 32'(write_enabled), 32'(!l.err && l.rd != 5'd0));
    chk("pending_after_commit", pending_mask, 32'd0);
    chk("error_after_commit", 32'(load_error), 32'd0);
    chk("busy_after_commit", 32'(load_busy), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    loads[0]  = '{5'd7,  3'b000, 2'd2, 32'h12803456, 32'hFFFFFF80, 1'b0, 2};
    loads[1]  = '{5'd3,  3'b101, 2'd2, 32'hABCD1234, 32'h0000ABCD, 1'b0, 0};
    loads[2]  = '{5'd4,  3'b010, 2'd1, 32'hABCD1234, 32'h00000000, 1'b1, 1};
    loads[3]  = '{5'd5,  3'b001, 2'd0, 32'hABCD8001, 32'hFFFF8001, 1'b0, 0};
    loads[4]  = '{5'd6,  3'b100, 2'd3, 32'hABCD1234, 32'h000000AB, 1'b0, 1};
    loads[5]  = '{5'd8,  3'b000, 2'd1, 32'h00007F00, 32'h0000007F, 1'b0, 0};
    loads[6]  = '{5'd11, 3'b010, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2};
    loads[7]  = '{5'd13, 3'b011, 2'd0, 32'h11111111, 32'h00000000, 1'b1, 0};
    loads[8]  = '{5'd14, 3'b101, 2'd1, 32'h22222222, 32'h00000000, 1'b1, 0};
    loads[9]  = '{5'd0,  3'b010, 2'd0, 32'h12345678, 32'h00000000, 1'b0, 0};
    loads[10] = '{5'd31, 3'b001, 2'd2, 32'h80000000, 32'hFFFF8000, 1'b0, 1};

    // Reset state
    step();
    step();
    chk("rst_write_enabled", 32'(write_enabled), 32'd0);
    chk("rst_write_index", 32'(write_index), 32'd0);
    chk("rst_write_value", write_value, 32'd0);
    chk("rst_pending", pending_mask, 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    rst = 1'b0;

    // ALU only, including a suppressed x0 write
    step();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_value = 32'hDEADBEEF;
    exp_wr.push_back('{idx: 5'd5, val: 32'hDEADBEEF});
    #1;
    chk("alu_ready_idle", 32'(alu_ready), 32'd1);
    step();
    chk("alu_write_latency", 32'(write_enabled), 32'd1);
    alu_rd    = 5'd0;
    alu_value = 32'h11111111;
    step();
    alu_valid = 1'b0;
    chk("alu_x0_no_write", 32'(write_enabled), 32'd0);

    // Load extraction and error table
    foreach (loads[i]) do_load(loads[i]);

    // WAW stall against outstanding load to x9; x10 passes through
    step();
    load_issue  = 1'b1;
    load_rd     = 5'd9;
    load_funct3 = 3'b010;
    load_offset = 2'd0;
    step();
    load_issue = 1'b0;
    alu_valid  = 1'b1;
    alu_rd     = 5'd9;
    alu_value  = 32'h00000099;
    #1;
    chk("waw_stall_1", 32'(alu_ready), 32'd0);
    step();
    chk("waw_stall_2", 32'(alu_ready), 32'd0);
    alu_rd    = 5'd10;
    alu_value = 32'h000000A0;
    exp_wr.push_back('{idx: 5'd10, val: 32'h000000A0});
    #1;
    chk("waw_other_rd_ready", 32'(alu_ready), 32'd1);
    step();
    chk("waw_other_rd_written", 32'(write_enabled), 32'd1);
    alu_rd     = 5'd9;
    alu_value  = 32'h00000099;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00000042;
    exp_wr.push_back('{idx: 5'd9, val: 32'h00000042});
    #1;
    chk("waw_stall_3", 32'(alu_ready), 32'd0);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("commit_alu_blocked", 32'(alu_ready), 32'd0);
    step();
    exp_wr.push_back('{idx: 5'd9, val: 32'h00000099});
    #1;
    chk("waw_released", 32'(alu_ready), 32'd1);
    chk("waw_load_written", 32'(write_index), 32'd9);
    step();
    alu_valid = 1'b0;

    // Issue plus ALU together in IDLE, then the load times out
    load_issue  = 1'b1;
    load_rd     = 5'd12;
    load_funct3 = 3'b010;
    load_offset = 2'd0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd13;
    alu_value   = 32'h00001313;
    exp_wr.push_back('{idx: 5'd13, val: 32'h00001313});
    step();
    load_issue = 1'b0;
    alu_valid  = 1'b0;
    chk("dual_accept_alu_write", 32'(write_enabled), 32'd1);
    chk("dual_accept_busy", 32'(load_busy), 32'd1);
    step();
    step();
    step();
    chk("timeout_pending", pending_mask, 32'h00001000);
    chk("timeout_no_early_error", 32'(load_error), 32'd0);
    exp_err.push_back(5'd12);
    step();
    chk("timeout_error", 32'(load_error), 32'd1);
    chk("timeout_idle", 32'(load_busy), 32'd0);
    chk("timeout_pending_clear", pending_mask, 32'd0);
    chk("timeout_no_write", 32'(write_enabled), 32'd0);

    // Stray rvalid in IDLE is ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    step();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_busy", 32'(load_busy), 32'd0);
    step();
    chk("idle_rvalid_no_write", 32'(write_enabled), 32'd0);

    // Asynchronous reset in the middle of a load
    load_issue  = 1'b1;
    load_rd     = 5'd20;
    load_funct3 = 3'b010;
    load_offset = 2'd0;
    step();
    load_issue = 1'b0;
    chk("midload_pending", pending_mask, 32'h00100000);
    #2;
    rst = 1'b1;
    #1;
    chk("midload_rst_busy", 32'(load_busy), 32'd0);
    chk("midload_rst_pending", pending_mask, 32'd0);
    chk("midload_rst_write_index", 32'(write_index), 32'd0);
    chk("midload_rst_write_value", write_value, 32'd0);
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    step();
    mem_rvalid = 1'b0;
    chk("post_rst_busy", 32'(load_busy), 32'd0);
    step();
    chk("post_rst_no_write", 32'(write_enabled), 32'd0);
    step();

    chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    chk("errors_outstanding", 32'(exp_err.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side driver for the 32x32 register bank: owns its single write port (write_enabled / write_index / write_value).
- Merges single-cycle ALU results with variable-latency memory load returns.
- Performs RV32I load byte/halfword extraction and sign/zero extension.
- Exports a pending-destination scoreboard so decode can stall on RAW hazards against an outstanding load.

Parameters:
TIMEOUT_CYCLES, 255, cycles waited for mem_rvalid before the load is abandoned; 1..65535.
TIMEOUT_WIDTH, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
alu_valid  in  1  ALU result offered this cycle.
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
alu_rd  in  5  ALU destination register.
alu_value  in  32  ALU result.
load_issue  in  1  single-cycle pulse: a load was issued to memory.
load_rd  in  5  load destination register.
load_funct3  in  3  RV32I load funct3.
load_offset  in  2  address[1:0] of the load.
mem_rvalid  in  1  memory read data valid, single-cycle pulse.
mem_rdata  in  32  aligned 32-bit word containing the load data.
write_enabled  out  1  register write strobe (registered).
write_index  out  5  register write index (registered).
write_value  out  32  register write data (registered).
pending_mask  out  32  bit n set while a load to xn is outstanding; bit 0 always 0.
load_busy  out  1  high in any state other than IDLE.
load_error  out  1  one-cycle pulse on illegal funct3, misalignment, or timeout.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - write_enabled=0, write_index=0, write_value=0.
  - pending_mask=0, load_error=0, timeout counter=0.
  - Any outstanding load is discarded.
- State IDLE:
  - alu_ready=1.
  - load_issue latches rd/funct3/offset, sets pending_mask[load_rd] (unless rd=0), clears the counter, and moves to WAIT_LOAD.
- State WAIT_LOAD:
  - Counter increments each cycle.
  - alu_ready=0 if alu_rd==latched rd, to block WAW; otherwise alu_ready=1.
  - mem_rvalid: latch mem_rdata, go to COMMIT.
  - Counter reaching TIMEOUT_CYCLES without mem_rvalid: pulse load_error, clear the pending bit, return to IDLE; no write.
- State COMMIT:
  - alu_ready=0; the load owns the write port this cycle.
  - Drive the extracted load value to the write port registers.
  - Clear the pending bit; return to IDLE.
- Write latency: accepted ALU beat or COMMIT state produces write_enabled=1 on the next cycle; otherwise write_enabled=0 that cycle.
- rd==0: write_enabled stays 0 for both ALU and load results; pending bit 0 is never set.
- Load extraction:
  - LB(000): sign-extend mem_rdata byte at offset*8.
  - LH(001): sign-extend halfword at offset[1]*16.
  - LW(010): full word.
  - LBU(100), LHU(101): zero-extend.
  - LH/LHU with offset[0]=1, LW with offset!=0, and funct3 011/110/111 are errors:
    - load_error pulses in COMMIT.
    - No write occurs; the pending bit still clears.
- Simultaneous events:
  - load_issue and alu_valid together in IDLE: both are accepted; the ALU write occurs next cycle while the load waits.
  - load_issue while load_busy: ignored; the issuer must honour load_busy.
  - mem_rvalid in IDLE or COMMIT: ignored.
- pending_mask is combinational from the latched rd and state; it updates the cycle after load_issue.

Decomposition:
- Shared package holds:
  - load funct3 constants: LB, LH, LW, LBU, LHU.
  - state encoding: IDLE=2'd0, WAIT_LOAD=2'd1, COMMIT=2'd2.
  - REG_INDEX_WIDTH=5, XLEN=32.
- One sub-module: load_extract, purely combinational (funct3, offset, word) -> (value, misaligned/illegal flag). It is reusable by the memory stage for store-side checks.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_value=0xDEADBEEF in IDLE -> next cycle write_enabled=1, write_index=5, write_value=0xDEADBEEF; alu_rd=0 -> write_enabled=0.
- LB sign extension: load_issue rd=7 funct3=000 offset=2; 3 cycles later mem_rvalid with rdata=0x12803456:
  - pending_mask=0x80 during the wait.
  - Write x7=0xFFFFFF80 two cycles after rvalid.
  - pending_mask=0 afterwards.
- LHU/LW: rdata=0xABCD1234 with LHU offset=2 -> 0x0000ABCD; LW offset=1 -> load_error pulse, no write, pending cleared.
- WAW stall: load rd=9 outstanding, alu_valid with alu_rd=9 -> alu_ready=0 until COMMIT completes; alu_rd=10 in WAIT_LOAD -> accepted immediately.
- Timeout: TIMEOUT_CYCLES=4, load_issue with no mem_rvalid -> load_error pulse after 4 WAIT cycles, state IDLE, pending_mask=0, no write.
- Reset mid-load: rst asserted asynchronously during WAIT_LOAD -> immediately all outputs zero, load_busy=0; a later mem_rvalid produces no write.
